// File: rtl/lock_pkg.sv
// Shared definitions for the lock controller and its status decoder:
// 3-bit state codes and the 7-segment glyphs ({g,f,e,d,c,b,a}, active-high).
package lock_pkg;

  localparam logic [2:0] IDLE           = 3'b000;
  localparam logic [2:0] SET_AWAITING   = 3'b001;
  localparam logic [2:0] OPENED         = 3'b010;
  localparam logic [2:0] ALARM          = 3'b011;
  localparam logic [2:0] INPUT_PASSWORD = 3'b100;

  localparam logic [6:0] SEG_DASH = 7'b1000000;
  localparam logic [6:0] SEG_S    = 7'b1101101;
  localparam logic [6:0] SEG_O    = 7'b0111111;
  localparam logic [6:0] SEG_A    = 7'b1110111;
  localparam logic [6:0] SEG_P    = 7'b1110011;
  localparam logic [6:0] SEG_E    = 7'b1111001;

  function automatic logic [6:0] seg_decode(input logic [2:0] code);
    logic [6:0] s;
    case (code)
      IDLE:           s = SEG_DASH;
      SET_AWAITING:   s = SEG_S;
      OPENED:         s = SEG_O;
      ALARM:          s = SEG_A;
      INPUT_PASSWORD: s = SEG_P;
      default:        s = SEG_E;
    endcase
    return s;
  endfunction

  function automatic logic code_is_valid(input logic [2:0] code);
    return (code <= INPUT_PASSWORD);
  endfunction

endpackage

// File: rtl/code_debounce.sv
// Two-flop synchroniser followed by a stability filter. The output only
// follows the synchronised input once it has held the same value for
// STABLE_CYCLES consecutive clock edges; any change restarts the count.
module code_debounce #(
  parameter int WIDTH         = 3,
  parameter int STABLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  localparam int            CW      = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dout_q, dout_d;

  // Track how long the synchronised value has been unchanged; accept it once the run is long enough.
  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    dout_d = dout_q;
    if (sync2_q != cand_q) begin
      cand_d = sync2_q;
      cnt_d  = CW'(1);
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CW'(1);
    end
    if (cnt_d == CNT_MAX) begin
      dout_d = sync2_q;
    end
  end

  // Synchroniser and filter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      cand_q  <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/lock_status_decoder.sv
// Receive side of the lock state code: debounces the asynchronous code,
// drives the 7-segment glyph and status LEDs, times the alarm buzzer and
// keeps a saturating tally of alarm entries.
module lock_status_decoder
  import lock_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int BLINK_HALF    = 100,
  parameter int BEEP_CYCLES   = 500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] state_code,
  input  logic       clear_alarms,
  output logic [6:0] seg,
  output logic       code_valid,
  output logic       led_open,
  output logic       led_blink,
  output logic       buzzer,
  output logic [3:0] alarm_count
);

  localparam int             BLW         = $clog2(BLINK_HALF + 1);
  localparam int             BPW         = $clog2(BEEP_CYCLES + 1);
  localparam logic [BLW-1:0] HALF_RELOAD = BLW'(BLINK_HALF - 1);
  localparam logic [BPW-1:0] BEEP_RELOAD = BPW'(BEEP_CYCLES - 1);

  logic [2:0]     code_acc;
  logic [2:0]     prev_q;
  logic           in_alarm;
  logic           entry;

  logic [6:0]     seg_q, seg_d;
  logic           valid_q, valid_d;
  logic           open_q, open_d;
  logic           blink_q, blink_d;
  logic           buz_q, buz_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [BLW-1:0] half_q, half_d;
  logic [BPW-1:0] beep_q, beep_d;

  code_debounce #(
    .WIDTH         (3),
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_debounce (
    .clk  (clk),
    .rst  (rst),
    .din  (state_code),
    .dout (code_acc)
  );

  // Invalid codes never equal ALARM, so they can neither start nor hold a beep.
  assign in_alarm = (code_acc == ALARM);
  assign entry    = in_alarm && (prev_q != ALARM);

  // Next values for every registered output, derived from the accepted code.
  always_comb begin
    seg_d   = seg_decode(code_acc);
    valid_d = code_is_valid(code_acc);
    open_d  = (code_acc == OPENED);

    blink_d = 1'b0;
    half_d  = '0;
    if (entry) begin
      blink_d = 1'b1;
      half_d  = HALF_RELOAD;
    end else if (in_alarm) begin
      if (half_q == '0) begin
        blink_d = ~blink_q;
        half_d  = HALF_RELOAD;
      end else begin
        blink_d = blink_q;
        half_d  = half_q - BLW'(1);
      end
    end else begin
      blink_d = (code_acc == INPUT_PASSWORD);
    end

    buz_d  = 1'b0;
    beep_d = '0;
    if (entry) begin
      buz_d  = 1'b1;
      beep_d = BEEP_RELOAD;
    end else if (in_alarm && (beep_q != '0)) begin
      buz_d  = 1'b1;
      beep_d = beep_q - BPW'(1);
    end

    cnt_d = cnt_q;
    if (clear_alarms) begin
      cnt_d = entry ? 4'd1 : 4'd0;
    end else if (entry && (cnt_q != 4'hF)) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  // Output, timer and entry-detect registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q  <= IDLE;
      seg_q   <= SEG_DASH;
      valid_q <= 1'b1;
      open_q  <= 1'b0;
      blink_q <= 1'b0;
      buz_q   <= 1'b0;
      cnt_q   <= 4'd0;
      half_q  <= '0;
      beep_q  <= '0;
    end else begin
      prev_q  <= code_acc;
      seg_q   <= seg_d;
      valid_q <= valid_d;
      open_q  <= open_d;
      blink_q <= blink_d;
      buz_q   <= buz_d;
      cnt_q   <= cnt_d;
      half_q  <= half_d;
      beep_q  <= beep_d;
    end
  end

  assign seg         = seg_q;
  assign code_valid  = valid_q;
  assign led_open    = open_q;
  assign led_blink   = blink_q;
  assign buzzer      = buz_q;
  assign alarm_count = cnt_q;

endmodule
